// File: rtl/key_bounce_gen.sv
// -----------------------------------------------------------------------------
// key_bounce_gen
//
// Emulates a mechanical push-button for exercising debounce logic. One start
// request produces a full press/release sequence on key_out:
//   PRESS_BNC : BOUNCE_LEN cycles of pseudo-random chatter (LFSR bit 0)
//   HOLD      : HOLD_LEN cycles held solidly low (pressed)
//   REL_BNC   : BOUNCE_LEN cycles of pseudo-random chatter
// followed by a return to IDLE, where key_out rests high.
//
// Parameters
//   BOUNCE_LEN : chatter length on press and on release, 1..1048575 cycles
//   HOLD_LEN   : stable-low length between the two chatter phases, 1..1048575
//   LFSR_SEED  : LFSR reset value, must be nonzero
//
// Ports
//   sys_clk   in   1  rising-edge clock
//   sys_rst_n in   1  asynchronous active-low reset
//   start     in   1  request one sequence; honoured only in IDLE, never queued
//   key_out   out  1  emulated key line, idle high / pressed low (registered)
//   busy      out  1  high for the whole press/hold/release sequence (registered)
//   done      out  1  one-cycle pulse in the first IDLE cycle after a sequence
//   press_cnt out  8  completed sequences since reset, wraps 255 -> 0
// -----------------------------------------------------------------------------
module key_bounce_gen #(
    parameter logic [19:0] BOUNCE_LEN = 20'd30,
    parameter logic [19:0] HOLD_LEN   = 20'd100,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_BNC = 2'd1,
        HOLD      = 2'd2,
        REL_BNC   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] phase;
    logic [19:0] phase_nxt;
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;
    logic        key_nxt;
    logic        busy_nxt;
    logic        done_nxt;
    logic [7:0]  cnt_nxt;

    // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting right; taps 0,2,3,5.
    // It free-runs in every state so the chatter differs between sequences.
    assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // Next-state logic. The phase counter clears on every state entry and
    // compares against LEN-1, so it never wraps inside a state. In IDLE it is
    // parked at zero since IDLE has no bounded length.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path can leave one unassigned and infer a latch.
        state_nxt = state;
        phase_nxt = phase + 20'd1;
        done_nxt  = 1'b0;
        cnt_nxt   = press_cnt;

        case (state)
            IDLE: begin
                phase_nxt = '0;
                if (start) begin
                    state_nxt = PRESS_BNC;
                end
            end
            PRESS_BNC: begin
                if (phase == BOUNCE_LEN - 20'd1) begin
                    state_nxt = HOLD;
                    phase_nxt = '0;
                end
            end
            HOLD: begin
                if (phase == HOLD_LEN - 20'd1) begin
                    state_nxt = REL_BNC;
                    phase_nxt = '0;
                end
            end
            REL_BNC: begin
                if (phase == BOUNCE_LEN - 20'd1) begin
                    state_nxt = IDLE;
                    phase_nxt = '0;
                    done_nxt  = 1'b1;
                    cnt_nxt   = press_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so that, once registered, they
    // line up with the state they describe (start at edge k -> busy and chatter
    // visible right after edge k). During chatter key_out tracks bit 0 of the
    // LFSR value being loaded on the same edge.
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        case (state_nxt)
            PRESS_BNC, REL_BNC: key_nxt = lfsr_nxt[0];
            HOLD:               key_nxt = 1'b0;
            default:            key_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            phase     <= '0;
            lfsr      <= LFSR_SEED;
            key_out   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            press_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state     <= state_nxt;
            phase     <= phase_nxt;
            lfsr      <= lfsr_nxt;
            key_out   <= key_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            press_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_key_bounce_gen.sv
// -----------------------------------------------------------------------------
// tb_key_bounce_gen
//
// Self-checking bench for key_bounce_gen. A default-parameter instance covers
// single sequences, ignored starts, mid-sequence reset and counter wrap; a
// BOUNCE_LEN=1/HOLD_LEN=1 instance covers back-to-back sequences with start
// held high. Expected press counts are pushed to a queue when a start is
// issued and popped when the DUT pulses done. Chatter is compared bit-exact
// against an independent LFSR model, and key_out feeds a debounce model
// (CNT_MAX=24) that must flag exactly once per sequence.
// -----------------------------------------------------------------------------
module tb_key_bounce_gen;

    localparam int BL      = 30;
    localparam int HL      = 100;
    localparam int SEQ     = 2 * BL + HL;
    localparam int CNT_MAX = 24;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       start     = 1'b0;
    logic       start_s   = 1'b0;
    logic       key_out, busy, done;
    logic [7:0] press_cnt;
    logic       key_s, busy_s, done_s;
    logic [7:0] cnt_s;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] sb_q[$];
    logic [7:0] exp_cnt  = 8'd0;
    logic [7:0] sb_exp;

    key_bounce_gen dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .key_out   (key_out),
        .busy      (busy),
        .done      (done),
        .press_cnt (press_cnt)
    );

    key_bounce_gen #(
        .BOUNCE_LEN (20'd1),
        .HOLD_LEN   (20'd1)
    ) dut_s (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start_s),
        .key_out   (key_s),
        .busy      (busy_s),
        .done      (done_s),
        .press_cnt (cnt_s)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, seeded 16'hACE1, stepping on
    // every rising edge out of reset.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) m_lfsr <= 16'hACE1;
        else            m_lfsr <= lfsr_step(m_lfsr);
    end

    // Debounce model: flags once after CNT_MAX consecutive low samples.
    int db_cnt    = 0;
    int key_flags = 0;
    always @(negedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            db_cnt <= 0;
        end else if (key_out) begin
            db_cnt <= 0;
        end else if (db_cnt < CNT_MAX) begin
            db_cnt <= db_cnt + 1;
            if (db_cnt == CNT_MAX - 1) key_flags <= key_flags + 1;
        end
    end

    task automatic test_reset;
        sys_rst_n = 1'b0;
        start     = 1'b1;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if ({key_out, busy, done, press_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL reset_state: key=%b busy=%b done=%b cnt=%0d, want 1 0 0 0",
                     key_out, busy, done, press_cnt);
        end
        n_checks++;
        if ({key_s, busy_s, done_s, cnt_s} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL reset_state_s: key=%b busy=%b done=%b cnt=%0d, want 1 0 0 0",
                     key_s, busy_s, done_s, cnt_s);
        end
        start     = 1'b0;
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        n_checks++;
        if ({key_out, busy} !== 2'b10) begin
            n_errors++;
            $display("FAIL start_in_reset_ignored: key=%b busy=%b, want 1 0", key_out, busy);
        end
    endtask

    // One full sequence on the default instance with per-cycle checks. With
    // inject set, extra start pulses land in busy cycles 5, 50 and 150.
    task automatic run_seq(input bit inject, input string tag);
        int   flags0;
        logic ek;
        flags0 = key_flags;
        start  = 1'b1;
        @(negedge sys_clk);
        start   = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        sb_q.push_back(exp_cnt);
        for (int c = 1; c <= SEQ; c++) begin
            ek = (c <= BL || c > BL + HL) ? m_lfsr[0] : 1'b0;
            n_checks++;
            if ({busy, done, key_out} !== {1'b1, 1'b0, ek}) begin
                n_errors++;
                $display("FAIL %s cycle %0d: busy=%b done=%b key=%b, want 1 0 %b",
                         tag, c, busy, done, key_out, ek);
            end
            start = inject && (c == 5 || c == 50 || c == 150);
            @(negedge sys_clk);
        end
        start = 1'b0;
        n_checks++;
        if ({done, busy, key_out} !== 3'b101) begin
            n_errors++;
            $display("FAIL %s done_cycle: done=%b busy=%b key=%b, want 1 0 1",
                     tag, done, busy, key_out);
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s scoreboard_empty: cnt=%0d", tag, press_cnt);
        end else begin
            sb_exp = sb_q.pop_front();
            if (press_cnt !== sb_exp) begin
                n_errors++;
                $display("FAIL %s press_cnt: got %0d, want %0d", tag, press_cnt, sb_exp);
            end
        end
        @(negedge sys_clk);
        n_checks++;
        if ({done, busy, key_out} !== 3'b001) begin
            n_errors++;
            $display("FAIL %s after_done: done=%b busy=%b key=%b, want 0 0 1",
                     tag, done, busy, key_out);
        end
        n_checks++;
        if (key_flags - flags0 != 1) begin
            n_errors++;
            $display("FAIL %s debounce_flags: got %0d, want 1", tag, key_flags - flags0);
        end
    endtask

    task automatic test_single;
        run_seq(1'b0, "single");
    endtask

    task automatic test_ignore_start;
        run_seq(1'b1, "ignore_start");
    endtask

    task automatic test_reset_mid;
        start = 1'b1;
        @(negedge sys_clk);
        start   = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        sb_q.push_back(exp_cnt);
        repeat (BL + 39) @(negedge sys_clk);   // now at HOLD cycle 40
        n_checks++;
        if ({busy, key_out} !== 2'b10) begin
            n_errors++;
            $display("FAIL mid_hold: busy=%b key=%b, want 1 0", busy, key_out);
        end
        #2 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({key_out, busy, done, press_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_errors++;
            $display("FAIL async_abort: key=%b busy=%b done=%b cnt=%0d, want 1 0 0 0",
                     key_out, busy, done, press_cnt);
        end
        sb_q.delete();
        exp_cnt = 8'd0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        run_seq(1'b0, "after_reset");
    endtask

    task automatic test_back_to_back;
        start_s = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge sys_clk);
            n_checks++;
            if ({busy_s, done_s} !== {(i % 4) != 0, (i % 4) == 0}) begin
                n_errors++;
                $display("FAIL b2b cycle %0d: busy=%b done=%b", i, busy_s, done_s);
            end
            if (i % 4 == 2 && key_s !== 1'b0) begin
                n_errors++;
                $display("FAIL b2b hold cycle %0d: key=%b, want 0", i, key_s);
            end
            if (i % 4 == 0 && key_s !== 1'b1) begin
                n_errors++;
                $display("FAIL b2b idle cycle %0d: key=%b, want 1", i, key_s);
            end
        end
        start_s = 1'b0;
        n_checks++;
        if (cnt_s !== 8'd10) begin
            n_errors++;
            $display("FAIL b2b press_cnt: got %0d, want 10", cnt_s);
        end
        @(negedge sys_clk);
        n_checks++;
        if (busy_s !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b stop: busy=%b, want 0", busy_s);
        end
    endtask

    task automatic test_wrap;
        bit found;
        sys_rst_n = 1'b0;
        sb_q.delete();
        exp_cnt = 8'd0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        for (int s = 0; s < 256; s++) begin
            start = 1'b1;
            @(negedge sys_clk);
            start   = 1'b0;
            exp_cnt = exp_cnt + 8'd1;
            sb_q.push_back(exp_cnt);
            found = 1'b0;
            for (int w = 0; w < 2 * SEQ && !found; w++) begin
                @(negedge sys_clk);
                if (done) found = 1'b1;
            end
            n_checks++;
            if (!found) begin
                n_errors++;
                $display("FAIL wrap timeout in sequence %0d", s);
                sb_q.delete();
            end else begin
                sb_exp = sb_q.pop_front();
                if (press_cnt !== sb_exp) begin
                    n_errors++;
                    $display("FAIL wrap press_cnt seq %0d: got %0d, want %0d",
                             s, press_cnt, sb_exp);
                end
            end
        end
        n_checks++;
        if (press_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL wrap final: got %0d, want 0", press_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_wrap();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover: %0d entries, want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
